// File: rtl/div_iter_unit_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and the
// MIPS funct codes the decoder uses to pick DIV versus DIVU.
package div_iter_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  localparam logic [5:0] FUNCT_DIV  = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU = 6'h1b;

  // Decoder helper: DIV is the two's-complement flavour, DIVU the unsigned one.
  function automatic logic funct_is_signed(input logic [5:0] funct);
    return (funct == FUNCT_DIV);
  endfunction

endpackage

// File: rtl/div_iter_unit_sub_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor magnitude (A + ~B + 1 through 4-bit
// CLA slices), and keep the difference only when it does not go negative.
module div_sub_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  localparam int NSLICE = WIDTH / 4;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] b_inv;
  logic [WIDTH-1:0] diff;
  logic [NSLICE:0]  carry;
  logic             diff_top;

  assign shifted  = {rem_in, q_msb};
  assign b_inv    = ~divisor;
  assign carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NSLICE; gi++) begin : g_cla
      logic [3:0] a4, b4, g, p;
      logic [4:0] c;
      assign a4   = shifted[4*gi +: 4];
      assign b4   = b_inv[4*gi +: 4];
      assign g    = a4 & b4;
      assign p    = a4 ^ b4;
      assign c[0] = carry[gi];
      assign c[1] = g[0] | (p[0] & c[0]);
      assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & c[0]);
      assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & c[0]);
      assign diff[4*gi +: 4] = p ^ c[3:0];
      assign carry[gi+1]     = c[4];
    end
  endgenerate

  // Extra top bit: the zero-extended divisor inverts to 1 there.
  assign diff_top = shifted[WIDTH] ^ 1'b1 ^ carry[NSLICE];

  // Non-negative trial result means the divisor fits: take it and emit a 1.
  assign q_bit   = ~diff_top;
  assign rem_out = q_bit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_iter_unit.sv
// Multi-cycle restoring divider for DIV/DIVU. One quotient bit per cycle in
// CALC, sign fix-up and result registration in FIX. LO = quotient, HI = remainder.
module div_iter_unit
  import div_iter_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic             cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t state_reg, state_next;

  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] dvsr_mag_reg;
  logic [WIDTH-1:0] dvnd_reg;
  logic             signed_reg;
  logic             dvnd_neg_reg;
  logic             dvsr_neg_reg;
  logic             zero_reg;

  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             div_zero_reg;
  logic             done_reg;

  logic             accept;
  logic [WIDTH-1:0] dvnd_mag;
  logic [WIDTH-1:0] dvsr_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // A start is only taken from IDLE, and a simultaneous cancel drops it.
  assign accept   = (state_reg == ST_IDLE) && start && !cancel;
  assign dvnd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvsr_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  div_sub_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_reg),
    .q_msb   (q_reg[WIDTH-1]),
    .divisor (dvsr_mag_reg),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Sign fix-up of the magnitude results; divide-by-zero overrides them.
  always_comb begin
    q_fix = q_reg;
    r_fix = rem_reg;
    if (signed_reg) begin
      if (dvnd_neg_reg ^ dvsr_neg_reg) q_fix = -q_reg;
      if (dvnd_neg_reg)                r_fix = -rem_reg;
    end
    if (zero_reg) begin
      q_fix = '1;
      r_fix = dvnd_reg;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: IDLE -> CALC (WIDTH cycles) -> FIX -> IDLE, cancel aborts.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_CALC;
      ST_CALC: begin
        if (cancel)                state_next = ST_IDLE;
        else if (cnt_reg == CNT_ONE) state_next = ST_FIX;
      end
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, one shift/subtract per CALC cycle, result registration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      rem_reg       <= '0;
      q_reg         <= '0;
      dvsr_mag_reg  <= '0;
      dvnd_reg      <= '0;
      signed_reg    <= 1'b0;
      dvnd_neg_reg  <= 1'b0;
      dvsr_neg_reg  <= 1'b0;
      zero_reg      <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      div_zero_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            q_reg        <= dvnd_mag;
            rem_reg      <= '0;
            dvsr_mag_reg <= dvsr_mag;
            dvnd_reg     <= dividend;
            signed_reg   <= is_signed;
            dvnd_neg_reg <= dividend[WIDTH-1];
            dvsr_neg_reg <= divisor[WIDTH-1];
            zero_reg     <= (divisor == '0);
            cnt_reg      <= CNT_INIT;
          end
        end
        ST_CALC: begin
          if (cancel) begin
            cnt_reg <= '0;
          end else begin
            rem_reg <= step_rem;
            q_reg   <= {q_reg[WIDTH-2:0], step_q};
            cnt_reg <= cnt_reg - CNT_ONE;
          end
        end
        ST_FIX: begin
          if (!cancel) begin
            quotient_reg  <= q_fix;
            remainder_reg <= r_fix;
            div_zero_reg  <= zero_reg;
            done_reg      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_reg != ST_IDLE);
  assign done      = done_reg;
  assign div_zero  = div_zero_reg;
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit: directed spec cases, control
// scenarios and randomized operands against a plain-arithmetic model.
module tb_div_iter_unit;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;
  localparam int LAT   = WIDTH + 1;  // edges from start-sampling edge to done

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             is_signed = 1'b0;
  logic             cancel = 1'b0;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic             busy, done, div_zero;
  logic [WIDTH-1:0] quotient, remainder;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  div_iter_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .cancel(cancel), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .div_zero(div_zero),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: C truncating division, with the architectural special cases.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
    int sa, sb;
    sa = a;
    sb = b;
    z = (b == 32'd0);
    if (z) begin
      q = 32'hFFFFFFFF; r = a;
    end else if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      q = 32'h80000000; r = 32'd0;
    end else if (s) begin
      q = 32'(sa / sb); r = 32'(sa % sb);
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  // Launch one operation and wait (bounded) for done; returns what was observed.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s, input bit b2b,
                       output logic [31:0] q, output logic [31:0] r, output logic z,
                       output int lat, output int bcnt, output logic d0);
    int s0;
    if (!b2b) @(negedge clk);
    dividend = a; divisor = b; is_signed = s; start = 1'b1;
    @(negedge clk);
    s0 = cyc;
    d0 = done;
    start = 1'b0;
    dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
    lat = -1;
    bcnt = busy ? 1 : 0;
    for (int k = 0; k < LAT + 8; k++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - s0;
        break;
      end
      if (busy) bcnt++;
    end
    q = quotient; r = remainder; z = div_zero;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    repeat (3) @(negedge clk);
    start = 1'b0;
    n_cmp += 5;
    if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0)      begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    if (div_zero !== 1'b0)  begin n_bad++; $display("FAIL reset_div_zero got %b want 0", div_zero); end
    if (quotient !== '0)    begin n_bad++; $display("FAIL reset_quotient got %h want 0", quotient); end
    if (remainder !== '0)   begin n_bad++; $display("FAIL reset_remainder got %h want 0", remainder); end
    $display("reset: busy=%b done=%b q=%h r=%h", busy, done, quotient, remainder);
    rst_n = 1'b1;
  endtask

  logic [31:0] ta [7] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFB};
  logic [31:0] tb [7] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0};
  logic        ts [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [31:0] eq [7] = '{32'd14, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] er [7] = '{32'd2, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd5, 32'hFFFFFFFB};
  logic        ez [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  task automatic test_directed;
    logic [31:0] q, r; logic z, d0; int lat, bcnt;
    for (int i = 0; i < 7; i++) begin
      do_op(ta[i], tb[i], ts[i], 1'b0, q, r, z, lat, bcnt, d0);
      $display("directed %0d: s=%b a=%h b=%h q=%h r=%h z=%b lat=%0d busy=%0d",
               i, ts[i], ta[i], tb[i], q, r, z, lat, bcnt);
      n_cmp += 6;
      if (q !== eq[i])   begin n_bad++; $display("FAIL dir%0d_quotient got %h want %h", i, q, eq[i]); end
      if (r !== er[i])   begin n_bad++; $display("FAIL dir%0d_remainder got %h want %h", i, r, er[i]); end
      if (z !== ez[i])   begin n_bad++; $display("FAIL dir%0d_div_zero got %b want %b", i, z, ez[i]); end
      if (lat !== LAT)   begin n_bad++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, LAT); end
      if (bcnt !== LAT)  begin n_bad++; $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, bcnt, LAT); end
      if (busy !== 1'b0) begin n_bad++; $display("FAIL dir%0d_busy_at_done got %b want 0", i, busy); end
    end
  endtask

  task automatic test_start_busy;
    logic [31:0] wq, wr; logic wz; int s0, lat, ndone;
    ref_div(32'd1000, 32'd9, 1'b0, wq, wr, wz);
    @(negedge clk);
    dividend = 32'd1000; divisor = 32'd9; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    s0 = cyc; start = 1'b0;
    repeat (5) @(negedge clk);
    dividend = 32'd55; divisor = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < LAT + 8 && !done; k++) @(negedge clk);
    lat = done ? cyc - s0 : -1;
    $display("start_busy: q=%h r=%h lat=%0d", quotient, remainder, lat);
    n_cmp += 3;
    if (lat !== LAT)      begin n_bad++; $display("FAIL busy_start_latency got %0d want %0d", lat, LAT); end
    if (quotient !== wq)  begin n_bad++; $display("FAIL busy_start_quotient got %h want %h", quotient, wq); end
    if (remainder !== wr) begin n_bad++; $display("FAIL busy_start_remainder got %h want %h", remainder, wr); end
    ndone = 0;
    repeat (LAT + 5) begin @(negedge clk); if (done || busy) ndone++; end
    n_cmp++;
    if (ndone !== 0) begin n_bad++; $display("FAIL busy_start_queued got %0d activity cycles want 0", ndone); end
  endtask

  task automatic test_cancel;
    logic [31:0] q, r, wq, wr; logic z, d0, wz; int lat, bcnt, ndone;
    do_op(32'd1000, 32'd3, 1'b0, 1'b0, q, r, z, lat, bcnt, d0);
    @(negedge clk);
    dividend = 32'd77; divisor = 32'd0; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL cancel_busy got %b want 0", busy); end
    ndone = 0;
    repeat (LAT + 5) begin @(negedge clk); if (done) ndone++; end
    $display("cancel: q=%h r=%h z=%b dones=%0d", quotient, remainder, div_zero, ndone);
    n_cmp += 4;
    if (ndone !== 0)          begin n_bad++; $display("FAIL cancel_done got %0d pulses want 0", ndone); end
    if (quotient !== 32'd333) begin n_bad++; $display("FAIL cancel_hold_quotient got %h want %h", quotient, 32'd333); end
    if (remainder !== 32'd1)  begin n_bad++; $display("FAIL cancel_hold_remainder got %h want %h", remainder, 32'd1); end
    if (div_zero !== 1'b0)    begin n_bad++; $display("FAIL cancel_hold_div_zero got %b want 0", div_zero); end
    // Start together with cancel in IDLE: the start must be dropped.
    @(negedge clk);
    dividend = 32'd9; divisor = 32'd2; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL cancel_start_idle_busy got %b want 0", busy); end
    // A fresh operation afterwards completes normally.
    ref_div(32'hFFFFFF9C, 32'd7, 1'b1, wq, wr, wz);
    do_op(32'hFFFFFF9C, 32'd7, 1'b1, 1'b0, q, r, z, lat, bcnt, d0);
    $display("after_cancel: q=%h r=%h lat=%0d", q, r, lat);
    n_cmp += 3;
    if (q !== wq)    begin n_bad++; $display("FAIL after_cancel_quotient got %h want %h", q, wq); end
    if (r !== wr)    begin n_bad++; $display("FAIL after_cancel_remainder got %h want %h", r, wr); end
    if (lat !== LAT) begin n_bad++; $display("FAIL after_cancel_latency got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] q, r, wq, wr; logic z, d0, wz; int lat, bcnt;
    do_op(32'd12345, 32'd10, 1'b0, 1'b0, q, r, z, lat, bcnt, d0);
    n_cmp++;
    if (q !== 32'd1234) begin n_bad++; $display("FAIL b2b_first_quotient got %h want %h", q, 32'd1234); end
    ref_div(32'hFFFF0000, 32'hFFFFFFF0, 1'b1, wq, wr, wz);
    do_op(32'hFFFF0000, 32'hFFFFFFF0, 1'b1, 1'b1, q, r, z, lat, bcnt, d0);
    $display("back_to_back: q=%h r=%h lat=%0d d0=%b", q, r, lat, d0);
    n_cmp += 4;
    if (d0 !== 1'b0) begin n_bad++; $display("FAIL b2b_done_width got %b want 0", d0); end
    if (q !== wq)    begin n_bad++; $display("FAIL b2b_quotient got %h want %h", q, wq); end
    if (r !== wr)    begin n_bad++; $display("FAIL b2b_remainder got %h want %h", r, wr); end
    if (lat !== LAT) begin n_bad++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] q, r; logic z, d0; int lat, bcnt;
    do_op(32'd5, 32'd0, 1'b0, 1'b0, q, r, z, lat, bcnt, d0);
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    $display("reset_mid: busy=%b done=%b z=%b q=%h r=%h", busy, done, div_zero, quotient, remainder);
    n_cmp += 5;
    if (busy !== 1'b0)     begin n_bad++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    if (done !== 1'b0)     begin n_bad++; $display("FAIL rst_mid_done got %b want 0", done); end
    if (div_zero !== 1'b0) begin n_bad++; $display("FAIL rst_mid_div_zero got %b want 0", div_zero); end
    if (quotient !== '0)   begin n_bad++; $display("FAIL rst_mid_quotient got %h want 0", quotient); end
    if (remainder !== '0)  begin n_bad++; $display("FAIL rst_mid_remainder got %h want 0", remainder); end
    rst_n = 1'b1;
  endtask

  task automatic test_random;
    logic [31:0] a, b, q, r, wq, wr; logic s, z, d0, wz; int lat, bcnt;
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 7))
        0: a = $urandom_range(0, 255);
        1: a = 32'h80000000;
        2: a = -$urandom_range(1, 255);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = $urandom_range(1, 15);
        3: b = $urandom >> $urandom_range(0, 31);
        4: b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      s = 1'($urandom);
      ref_div(a, b, s, wq, wr, wz);
      do_op(a, b, s, 1'b0, q, r, z, lat, bcnt, d0);
      $display("rand %0d: s=%b a=%h b=%h q=%h r=%h z=%b lat=%0d", i, s, a, b, q, r, z, lat);
      n_cmp += 4;
      if (q !== wq)    begin n_bad++; $display("FAIL rand%0d_quotient got %h want %h", i, q, wq); end
      if (r !== wr)    begin n_bad++; $display("FAIL rand%0d_remainder got %h want %h", i, r, wr); end
      if (z !== wz)    begin n_bad++; $display("FAIL rand%0d_div_zero got %b want %b", i, z, wz); end
      if (lat !== LAT) begin n_bad++; $display("FAIL rand%0d_latency got %0d want %0d", i, lat, LAT); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_busy();
    test_cancel();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
